// File: rtl/vga_timing_if.sv
// Video timing bundle between the sync generator and the pixel/character generators.
// frame_count exists only when VGA_FRAME_COUNT_EN is defined.
interface vga_timing_if #(
    parameter int CW = 11
);
    logic          en;
    logic          p_tick;
    logic          hsync;
    logic          vsync;
    logic          video_on;
    logic [CW-1:0] pixel_x;
    logic [CW-1:0] pixel_y;
    logic          line_start;
    logic          frame_start;
`ifdef VGA_FRAME_COUNT_EN
    logic [15:0]   frame_count;

    modport master (
        input  en,
        output p_tick, hsync, vsync, video_on, pixel_x, pixel_y,
        output line_start, frame_start, frame_count
    );
    modport slave (
        output en,
        input  p_tick, hsync, vsync, video_on, pixel_x, pixel_y,
        input  line_start, frame_start, frame_count
    );
`else
    modport master (
        input  en,
        output p_tick, hsync, vsync, video_on, pixel_x, pixel_y,
        output line_start, frame_start
    );
    modport slave (
        output en,
        input  p_tick, hsync, vsync, video_on, pixel_x, pixel_y,
        input  line_start, frame_start
    );
`endif
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA sync/coordinate generator with a clk prescaler for the pixel rate.
// Define VGA_FRAME_COUNT_EN to add a 16-bit frame counter output.
module vga_timing_gen #(
    parameter int H_DISP  = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_DISP  = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33,
    parameter int CLK_DIV = 4,
    parameter int H_POL   = 0,
    parameter int V_POL   = 0,
    parameter int CW      = 11
) (
    input  logic         clk,
    input  logic         reset,
    vga_timing_if.master vga
);
    localparam int H_TOTAL  = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_DISP + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_DISP + H_FP;
    localparam int HS_END   = HS_START + H_SYNC - 1;
    localparam int VS_START = V_DISP + V_FP;
    localparam int VS_END   = VS_START + V_SYNC - 1;
    localparam int PW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [PW-1:0] PS_MAX = PW'(CLK_DIV - 1);
    localparam logic [CW-1:0] H_MAX  = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_MAX  = CW'(V_TOTAL - 1);
    localparam logic          H_ACT  = 1'(H_POL);
    localparam logic          V_ACT  = 1'(V_POL);

    logic [PW-1:0] prescaler, prescaler_next;
    logic [CW-1:0] h_cnt, h_next;
    logic [CW-1:0] v_cnt, v_next;
    logic          p_tick;
    logic          hsync_q, vsync_q, video_on_q;

    assign p_tick = vga.en && (prescaler == PS_MAX);

    always_comb begin
        prescaler_next = prescaler;
        h_next         = h_cnt;
        v_next         = v_cnt;
        if (vga.en) begin
            prescaler_next = (prescaler == PS_MAX) ? '0 : prescaler + 1'b1;
        end
        if (p_tick) begin
            if (h_cnt == H_MAX) begin
                h_next = '0;
                v_next = (v_cnt == V_MAX) ? '0 : v_cnt + 1'b1;
            end else begin
                h_next = h_cnt + 1'b1;
            end
        end
    end

    // Sync/blank flags are derived from the next coordinates so they line up with pixel_x/pixel_y.
    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler  <= '0;
            h_cnt      <= '0;
            v_cnt      <= '0;
            hsync_q    <= ~H_ACT;
            vsync_q    <= ~V_ACT;
            video_on_q <= 1'b1;
        end else begin
            prescaler  <= prescaler_next;
            h_cnt      <= h_next;
            v_cnt      <= v_next;
            hsync_q    <= (h_next >= CW'(HS_START) && h_next <= CW'(HS_END)) ? H_ACT : ~H_ACT;
            vsync_q    <= (v_next >= CW'(VS_START) && v_next <= CW'(VS_END)) ? V_ACT : ~V_ACT;
            video_on_q <= (h_next < CW'(H_DISP)) && (v_next < CW'(V_DISP));
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    logic [15:0] frame_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt <= '0;
        end else if (p_tick && h_cnt == H_MAX && v_cnt == V_MAX) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

    assign vga.frame_count = frame_cnt;
`endif

    assign vga.p_tick      = p_tick;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.video_on    = video_on_q;
    assign vga.pixel_x     = h_cnt;
    assign vga.pixel_y     = v_cnt;
    assign vga.line_start  = p_tick && (h_cnt == '0);
    assign vga.frame_start = p_tick && (h_cnt == '0) && (v_cnt == '0);
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 640x480 VGA sync generator.
- Produces hsync/vsync, video_on, pixel coordinates and a pixel-rate strobe from the single system clock.
- Timing set, clock-divide ratio and sync polarity are all parameters, so one block serves every mode the display path needs.
- Adds line/frame start strobes and a run-enable; sits between the system clock domain and the pixel/character generators.

Parameters:
- H_DISP, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, pixels after the visible region.
- H_SYNC, 96: horizontal sync width, pixels.
- H_BP, 48: horizontal back porch, pixels.
- V_DISP, 480: visible lines per frame.
- V_FP, 10: vertical front porch, lines.
- V_SYNC, 2: vertical sync width, lines.
- V_BP, 33: vertical back porch, lines.
- CLK_DIV, 4: system clocks per pixel; must be at least 1.
- H_POL, 0: hsync active level (0 = active-low).
- V_POL, 0: vsync active level (0 = active-low).
- CW, 11: coordinate/counter width; must hold H_TOTAL-1 and V_TOTAL-1.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: synchronous, active-high reset.
- en, in, 1: run enable; 0 freezes all timing.
- p_tick, out, 1: pixel strobe, one clk wide.
- hsync, out, 1: horizontal sync at the H_POL level when active.
- vsync, out, 1: vertical sync at the V_POL level when active.
- video_on, out, 1: current pixel is in the visible area.
- pixel_x, out, CW: horizontal count, 0..H_TOTAL-1.
- pixel_y, out, CW: vertical count, 0..V_TOTAL-1.
- line_start, out, 1: strobe on the p_tick where pixel_x==0.
- frame_start, out, 1: strobe on the p_tick where pixel_x==0 and pixel_y==0.

Behaviour:
- Derived totals: H_TOTAL = H_DISP+H_FP+H_SYNC+H_BP; V_TOTAL = V_DISP+V_FP+V_SYNC+V_BP.
- Prescaler:
  - Counts 0..CLK_DIV-1 while en=1 and wraps to 0.
  - p_tick = en && (prescaler == CLK_DIV-1), combinational.
  - With CLK_DIV=1, p_tick equals en.
- Horizontal counter:
  - Advances only on a clk edge where p_tick=1.
  - Wraps from H_TOTAL-1 to 0.
- Vertical counter:
  - Advances on a clk edge where p_tick=1 and h==H_TOTAL-1.
  - Wraps from V_TOTAL-1 to 0 on that same edge.
- hsync, vsync and video_on are registered. Each is computed from the next counter values, so it is always consistent with the current pixel_x/pixel_y, with zero skew.
  - hsync active when pixel_x is in [H_DISP+H_FP, H_DISP+H_FP+H_SYNC-1]; otherwise at the inactive level.
  - vsync active when pixel_y is in [V_DISP+V_FP, V_DISP+V_FP+V_SYNC-1].
  - video_on = (pixel_x < H_DISP) && (pixel_y < V_DISP).
- line_start = p_tick && pixel_x==0. frame_start = line_start && pixel_y==0. Both are combinational from the registers and one clk wide.
- en=0: prescaler, counters and registered outputs hold their values; p_tick, line_start and frame_start are 0. Resuming continues from the held prescaler value, with no lost or extra pixel.
- Reset values (takes priority over en; mid-frame reset restarts cleanly at (0,0) on the next edge):
  - prescaler=0, pixel_x=0, pixel_y=0.
  - video_on=1.
  - hsync=~H_POL, vsync=~V_POL (inactive levels).
- First p_tick after reset is released (en=1): on clk cycle CLK_DIV, counting the first post-reset edge as cycle 1.
- Frame length: H_TOTAL*V_TOTAL*CLK_DIV clocks while en=1. Defaults give 800*525*4 = 1,680,000.
- No checks are made for parameter combinations that violate the width rules; the integrator sizes CW.

Optional Feature:
- Macro: VGA_FRAME_COUNT_EN.
- Defined:
  - Adds output frame_count, 16 bits, reset value 0.
  - Increments on the same edge where both counters wrap to (0,0); wraps 0xFFFF to 0.
  - Holds while en=0.
- Undefined: port absent, no extra logic; all other behaviour unchanged.

Test Plan:
- Defaults, en=1, release reset -> p_tick first high on cycle 4, then every 4 clocks; pixel_x steps 0,1,2,...
- Defaults, run one line -> hsync low exactly for pixel_x 656..751 (96 pixels); pixel_x wraps 799->0; pixel_y increments 0->1 on that edge; line_start high at the wrap.
- Defaults, run full frame -> vsync low for pixel_y 490..491; video_on=0 for x>=640 or y>=480; frame_start period 1,680,000 clocks; with VGA_FRAME_COUNT_EN, frame_count=1 after first wrap.
- CLK_DIV=1, H_POL=1, V_POL=1, small mode (H 8/2/2/2, V 4/1/1/1) -> p_tick constant 1; hsync high for x 10..11; line 14 clocks; frame 98 clocks.
- Drop en for 7 clocks at pixel_x=100 mid-prescale -> all outputs frozen, no strobes; after resume, next p_tick lands exactly 7 clocks later than without the gap.
- Assert reset at pixel (500,300) -> next cycle pixel_x=0, pixel_y=0, video_on=1, hsync=vsync=1 (inactive), prescaler restarts; frame_count (if enabled)=0.
